// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
// Shared types and constants for the PRBS receive checker.
//   state_t   : checker state encoding (SEARCH / VERIFY / LOCKED)
//   TAP_*     : history indices used to predict the next sequence bit
//   HIST_W    : history width (generator order + 1)
//   FILL_W    : width of the history fill counter
//   predict() : next-bit prediction from the history register
// ---------------------------------------------------------------------------
package prbs_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int HIST_W = 10;
   localparam int FILL_W = 4;

   // hist[0] is the newest bit, so s[n] = s[n-1] ^ s[n-5] ^ s[n-10]
   // maps onto history indices 0, 4 and 9.
   localparam int TAP_A = 0;
   localparam int TAP_B = 4;
   localparam int TAP_C = 9;

   function automatic logic predict(input logic [HIST_W-1:0] hist);
      return hist[TAP_A] ^ hist[TAP_B] ^ hist[TAP_C];
   endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear; clear has priority over inc.
//   Clk    : clock
//   Reset  : asynchronous active-high reset
//   clr    : synchronous clear to zero
//   inc    : increment by one unless already all-ones
//   count  : registered count value
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
// Receive-side checker for the 10-bit PRBS generator (feedback
// r[9]^r[5]^r[0], shift right, serial output q[0]). It self-synchronises to
// the incoming stream, reports lock and counts bit errors while locked.
//   Clk        : clock
//   Reset      : asynchronous active-high reset
//   clear      : synchronous clear of err_count and bit_count
//   in_valid   : in_bit is valid this cycle
//   in_bit     : received sequence bit
//   locked     : checker is in LOCKED
//   err_pulse  : one-cycle pulse per mismatch detected in LOCKED
//   err_count  : saturating count of LOCKED mismatches
//   bit_count  : saturating count of bits accepted while LOCKED
//   state      : 0=SEARCH, 1=VERIFY, 2=LOCKED
// ---------------------------------------------------------------------------
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int N          = 9,
   parameter int LOCK_COUNT = 16,
   parameter int LOSE_COUNT = 3,
   parameter int ERR_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [31:0]      bit_count,
   output logic [1:0]       state
);

   // Taps and prediction are hard-wired for the order-9 generator.
   generate
      if (N != 9) begin : g_bad_order
         $error("prbs_checker: only N = 9 is supported");
      end
   endgenerate

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W  = $clog2(LOSE_COUNT + 1);

   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSE_COUNT - 1);
   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(HIST_W - 1);

   state_t              state_reg,     state_next;
   logic [HIST_W-1:0]   hist_reg,      hist_next;
   logic [FILL_W-1:0]   fill_cnt_reg,  fill_cnt_next;
   logic [MATCH_W-1:0]  match_cnt_reg, match_cnt_next;
   logic [MISS_W-1:0]   miss_cnt_reg,  miss_cnt_next;
   logic                err_pulse_reg, err_pulse_next;
   logic                locked_reg,    locked_next;

   logic pred;
   logic mismatch;
   logic err_inc;
   logic bit_inc;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= SEARCH;
         hist_reg      <= '0;
         fill_cnt_reg  <= '0;
         match_cnt_reg <= '0;
         miss_cnt_reg  <= '0;
         err_pulse_reg <= 1'b0;
         locked_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hist_reg      <= hist_next;
         fill_cnt_reg  <= fill_cnt_next;
         match_cnt_reg <= match_cnt_next;
         miss_cnt_reg  <= miss_cnt_next;
         err_pulse_reg <= err_pulse_next;
         locked_reg    <= locked_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      hist_next      = hist_reg;
      fill_cnt_next  = fill_cnt_reg;
      match_cnt_next = match_cnt_reg;
      miss_cnt_next  = miss_cnt_reg;
      err_pulse_next = 1'b0;
      err_inc        = 1'b0;
      bit_inc        = 1'b0;
      pred           = predict(hist_reg);
      mismatch       = in_bit ^ pred;

      if (in_valid) begin
         case (state_reg)
            SEARCH: begin
               hist_next     = {hist_reg[HIST_W-2:0], in_bit};
               fill_cnt_next = fill_cnt_reg + FILL_W'(1);
               if (fill_cnt_reg == FILL_LAST) begin
                  state_next     = VERIFY;
                  match_cnt_next = '0;
               end
            end

            VERIFY: begin
               // Received bits always feed the history here, so a mismatch
               // resynchronises the predictor on its own.
               hist_next = {hist_reg[HIST_W-2:0], in_bit};
               if (hist_reg == '0) begin
                  // Zero history predicts zero forever; never let it count.
                  match_cnt_next = '0;
               end else if (!mismatch) begin
                  match_cnt_next = match_cnt_reg + MATCH_W'(1);
                  if (match_cnt_reg == MATCH_LAST) begin
                     state_next    = LOCKED;
                     miss_cnt_next = '0;
                  end
               end else begin
                  match_cnt_next = '0;
               end
            end

            LOCKED: begin
               // Flywheel: the history follows its own prediction so isolated
               // line errors do not disturb later predictions.
               hist_next = {hist_reg[HIST_W-2:0], pred};
               bit_inc   = 1'b1;
               if (mismatch) begin
                  err_pulse_next = 1'b1;
                  err_inc        = 1'b1;
                  if (miss_cnt_reg == MISS_LAST) begin
                     state_next    = SEARCH;
                     fill_cnt_next = '0;
                     miss_cnt_next = '0;
                  end else begin
                     miss_cnt_next = miss_cnt_reg + MISS_W'(1);
                  end
               end else begin
                  miss_cnt_next = '0;
               end
            end

            default: begin
               state_next = SEARCH;
            end
         endcase
      end

      locked_next = (state_next == LOCKED);
   end

   sat_counter #(.W(ERR_W)) u_err_count (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (clear),
      .inc   (err_inc),
      .count (err_count)
   );

   sat_counter #(.W(32)) u_bit_count (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (clear),
      .inc   (bit_inc),
      .count (bit_count)
   );

   assign locked    = locked_reg;
   assign err_pulse = err_pulse_reg;
   assign state     = state_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker
// Directed bench for prbs_checker. A reference generator produces the stream;
// a second instance with a 4-bit error counter shares all inputs so counter
// saturation can be observed alongside the full-width instance.
// ---------------------------------------------------------------------------
module tb_prbs_checker;

   logic        Clk;
   logic        Reset;
   logic        clear;
   logic        in_valid;
   logic        in_bit;

   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic [31:0] bit_count;
   logic [1:0]  state;

   logic        locked_w4;
   logic        err_pulse_w4;
   logic [3:0]  err_count_w4;
   logic [31:0] bit_count_w4;
   logic [1:0]  state_w4;

   logic [9:0]  gen_reg;
   int          checks;
   int          errors;

   prbs_checker dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .bit_count (bit_count),
      .state     (state)
   );

   prbs_checker #(.ERR_W(4)) dut_w4 (
      .Clk       (Clk),
      .Reset     (Reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .locked    (locked_w4),
      .err_pulse (err_pulse_w4),
      .err_count (err_count_w4),
      .bit_count (bit_count_w4),
      .state     (state_w4)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One clock cycle: present a bit (optionally inverted), advance the
   // reference generator when the bit is valid, then sample 1 ns after the edge.
   task automatic step(input logic v, input logic inv, input logic clr);
      in_valid = v;
      in_bit   = gen_reg[0] ^ inv;
      clear    = clr;
      @(posedge Clk);
      if (v) gen_reg = {gen_reg[9] ^ gen_reg[5] ^ gen_reg[0], gen_reg[9:1]};
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic do_reset();
      Reset    = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      clear    = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
   endtask

   initial begin
      int pulses;
      int nvalid;
      logic v;

      checks  = 0;
      errors  = 0;
      gen_reg = 10'd1;
      do_reset();

      // Reset state
      check("rst_state",     32'(state),     0);
      check("rst_locked",    32'(locked),    0);
      check("rst_err_pulse", 32'(err_pulse), 0);
      check("rst_err_count", 32'(err_count), 0);
      check("rst_bit_count", bit_count,      0);
      $display("reset: state=%0d locked=%0d", state, locked);

      // 1: acquire lock on a generator seeded to 1
      for (int k = 1; k <= 26; k++) begin
         step(1'b1, 1'b0, 1'b0);
         check($sformatf("acq_state_%0d", k), 32'(state), (k < 10) ? 0 : ((k < 26) ? 1 : 2));
         check($sformatf("acq_locked_%0d", k), 32'(locked), (k == 26) ? 1 : 0);
      end
      check("acq_err_count", 32'(err_count), 0);
      check("acq_bit_count", bit_count, 0);
      $display("acquire: 26 bits state=%0d locked=%0d", state, locked);

      // 2: single inverted bit while locked
      repeat (5) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("single_pulse",  32'(err_pulse), 1);
      check("single_count",  32'(err_count), 1);
      check("single_locked", 32'(locked),    1);
      pulses = 0;
      for (int k = 0; k < 100; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (k == 0) check("single_pulse_drop", 32'(err_pulse), 0);
         pulses += int'(err_pulse);
      end
      check("single_no_more_pulses", 32'(pulses), 0);
      check("single_count_after", 32'(err_count), 1);
      check("single_locked_after", 32'(locked), 1);
      check("single_bit_count", bit_count, 106);
      $display("single error: err_count=%0d bit_count=%0d", err_count, bit_count);

      // 3: three consecutive errors drop lock, then relock
      step(1'b0, 1'b0, 1'b1);
      check("clear_err_count", 32'(err_count), 0);
      check("clear_bit_count", bit_count, 0);
      check("clear_keeps_lock", 32'(locked), 1);
      for (int k = 1; k <= 3; k++) begin
         step(1'b1, 1'b1, 1'b0);
         check($sformatf("lose_locked_%0d", k), 32'(locked), (k < 3) ? 1 : 0);
      end
      check("lose_state", 32'(state), 0);
      check("lose_err_count", 32'(err_count), 3);
      for (int k = 1; k <= 26; k++) begin
         step(1'b1, 1'b0, 1'b0);
         check($sformatf("relock_%0d", k), 32'(locked), (k == 26) ? 1 : 0);
      end
      $display("lose/relock: err_count=%0d locked=%0d", err_count, locked);

      // 5: saturation of the 4-bit counter, then clear beating an error
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check($sformatf("sat_w4_%0d", i), 32'(err_count_w4), (i + 1 > 15) ? 15 : i + 1);
         check($sformatf("sat_w16_%0d", i), 32'(err_count), 32'(i + 1));
         repeat (4) step(1'b1, 1'b0, 1'b0);
      end
      check("sat_locked", 32'(locked_w4), 1);
      step(1'b1, 1'b1, 1'b1);
      check("clear_wins_w4",  32'(err_count_w4), 0);
      check("clear_wins_w16", 32'(err_count),    0);
      check("clear_wins_pulse", 32'(err_pulse),  1);
      $display("saturation: err_count_w4=%0d err_count=%0d", err_count_w4, err_count);

      // 4: all-zero stream never locks
      do_reset();
      gen_reg = 10'd0;
      for (int k = 1; k <= 40; k++) begin
         step(1'b1, 1'b0, 1'b0);
         check($sformatf("zero_state_%0d", k), 32'(state), (k < 10) ? 0 : 1);
      end
      check("zero_locked", 32'(locked), 0);
      check("zero_err_count", 32'(err_count), 0);
      $display("all-zero: state=%0d locked=%0d", state, locked);

      // 6: gapped valid while locked, then asynchronous reset
      do_reset();
      gen_reg = 10'd1;
      repeat (26) step(1'b1, 1'b0, 1'b0);
      check("gap_locked", 32'(locked), 1);
      nvalid = 0;
      for (int i = 0; i < 40; i++) begin
         v = (i % 2 == 0);
         step(v, 1'b0, 1'b0);
         if (v) nvalid++;
      end
      check("gap_bit_count", bit_count, 32'(nvalid));
      check("gap_still_locked", 32'(locked), 1);
      $display("gapped: bit_count=%0d valid=%0d", bit_count, nvalid);

      @(negedge Clk);
      Reset = 1'b1;
      #1;
      check("async_locked",    32'(locked),    0);
      check("async_state",     32'(state),     0);
      check("async_bit_count", bit_count,      0);
      check("async_err_count", 32'(err_count), 0);
      check("async_err_pulse", 32'(err_pulse), 0);
      $display("async reset: locked=%0d state=%0d", locked, state);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side checker for the 10-bit pseudo-random generator: LFSR with feedback r[9]^r[5]^r[0] and shift-right, whose serial output is q[0] each cycle.
- Accepts one bit per valid cycle and self-synchronises to the sequence.
- Reports lock status and counts bit errors.
- Used to validate the random source and any serial path it drives, e.g. ghost-AI randomness over the SoC bus and self-test on the FPGA.

Parameters:
- N, 9, generator order; history width N+1. Only 9 is supported; any other value is an elaboration error.
- LOCK_COUNT, 16, consecutive correct predictions needed to declare lock.
- LOSE_COUNT, 3, consecutive mispredictions in LOCKED that drop lock.
- ERR_W, 16, width of the saturating error counter.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous active-high reset
- clear  in  1  synchronous clear of err_count and bit_count
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  received sequence bit, i.e. the generator's q[0]
- locked  out  1  checker is in LOCKED
- err_pulse  out  1  one-cycle pulse for a mismatch detected in LOCKED
- err_count  out  ERR_W  saturating count of LOCKED mismatches
- bit_count  out  32  saturating count of bits accepted while LOCKED
- state  out  2  0=SEARCH, 1=VERIFY, 2=LOCKED

Behaviour:
- Reset (asynchronous, active-high) clears:
  - hist = 0, fill_cnt = 0, match_cnt = 0, miss_cnt = 0
  - state = SEARCH
  - all outputs 0
- All outputs are registered. Every response occurs on the clock edge that accepts the bit; it is visible the following cycle.
- Cycles with in_valid=0 change nothing except clear.
- hist[0] is the newest accepted bit. Shifting means hist <= {hist[8:0], b}.
- Prediction: pred = hist[0]^hist[4]^hist[9]. This follows from s[n] = s[n-1]^s[n-5]^s[n-10].
- SEARCH:
  - Each valid bit shifts in_bit into hist and increments fill_cnt.
  - On the 10th bit, go to VERIFY with match_cnt = 0.
- VERIFY:
  - Compare in_bit against pred, then shift in_bit into hist.
  - If hist is all-zero before the shift, the comparison does not count: match_cnt is held at 0 and the state stays VERIFY. An all-zero stream must never lock.
  - Match: match_cnt++. If match_cnt reaches LOCK_COUNT, go to LOCKED with miss_cnt = 0.
  - Mismatch: match_cnt = 0 and stay in VERIFY (the shifted-in received bit resynchronises the history).
  - No err_pulse and no err_count change while in VERIFY.
- LOCKED (flywheel mode):
  - hist shifts in pred, not in_bit, so a single error cannot corrupt the future prediction.
  - bit_count++ for each accepted bit.
  - Match: miss_cnt = 0.
  - Mismatch: err_pulse = 1 for one cycle, err_count++, miss_cnt++.
  - If miss_cnt reaches LOSE_COUNT, go to SEARCH with fill_cnt = 0. hist is kept but refilled over the next 10 bits.
- Counters saturate at all-ones and never wrap.
- clear and an error on the same edge: clear wins, err_count = 0. clear does not affect state, hist or lock.
- Reset asserted mid-lock drops locked and err_pulse immediately, without waiting for a clock edge.
- Latency: lock is declared at the earliest on the edge accepting the 26th valid bit (10 fill + 16 matches).

Decomposition:
- Package prbs_pkg holds:
  - state enum (SEARCH/VERIFY/LOCKED)
  - tap constants TAP_A=0, TAP_B=4, TAP_C=9 (history indices)
  - width localparams
- Sub-module sat_counter (parameterised width, inc/clr, saturating) is instantiated for err_count and bit_count.

Test Plan:
1. Reset, then drive a generator seeded to 1: the stream is 1,0,0,0,0,0,0,0,0,0,1,... with in_valid high continuously -> state 0 for 10 bits, then 1; locked=1 the cycle after the 26th bit; err_count=0.
2. Locked; invert exactly one bit -> err_pulse high for exactly one cycle, err_count=1, locked stays 1, no further pulses over the next 100 bits.
3. Locked; invert 3 consecutive bits -> err_count=3, locked=0 after the 3rd, state=0; correct stream resumes -> relock 26 bits later.
4. 40 all-zero bits after reset -> state never reaches 2, locked=0, err_count=0.
5. ERR_W=4, locked, 20 isolated single-bit errors -> err_count saturates at 15. Assert clear on the edge of another error -> err_count=0.
6. Toggle in_valid 50% while locked -> bit_count equals the number of valid cycles. Assert Reset mid-stream -> locked, state and counters 0 before the next clock edge.
